// File: rtl/keypad_digit_buf_if.sv
// rtl/keypad_digit_buf_if.sv - scanner-side inputs and display-side outputs of the keypad digit buffer
//
// Bundles the keypad buffer's signals other than clock and reset.
// master: scanner/controller side (drives clear, valid, scan_data).
// slave : the buffer itself (drives digits, cursor, full, en, err).
//   clear      synchronous clear, same effect as reset
//   valid      scanner key-present level
//   scan_data  one-hot key code (bit0..8 = 1..9, bit9 = *, bit10 = 0, bit11 = #)
//   digits     NDIG BCD slots, slot i at [4i+3:4i]
//   cursor     current write position
//   full       cursor at its upper limit
//   en         sticky commit flag
//   err        one-cycle rejected-press pulse
interface keypad_digit_buf_if #(
    parameter int NDIG = 6,
    parameter int CW   = $clog2(NDIG + 1)
);
    logic                clear;
    logic                valid;
    logic [11:0]         scan_data;
    logic [4*NDIG-1:0]   digits;
    logic [CW-1:0]       cursor;
    logic                full;
    logic                en;
    logic                err;

    modport master (
        output clear, valid, scan_data,
        input  digits, cursor, full, en, err
    );

    modport slave (
        input  clear, valid, scan_data,
        output digits, cursor, full, en, err
    );
endinterface

// File: rtl/keypad_digit_buf.sv
// rtl/keypad_digit_buf.sv - keypad digit-entry buffer with cursor / auto-advance modes
//
// Collects up to NDIG BCD digits from an edge-detected keypad press.
// AUTO_ADV=0: a digit overwrites the slot at the cursor, # moves the cursor on.
// AUTO_ADV=1: a digit is written and the cursor advances, # is backspace.
// * locks the entry (en) until reset or clear; any press while locked,
// any non-one-hot code, and any move past the cursor limits pulse err.
// NDIG must be at least 2.
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   keypad_digit_buf_if slave modport (clear, valid, scan_data in;
//         digits, cursor, full, en, err out)
module keypad_digit_buf #(
    parameter int NDIG     = 6,
    parameter int AUTO_ADV = 0,
    parameter int CW       = $clog2(NDIG + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_digit_buf_if.slave     bus
);

    logic [4*NDIG-1:0] digits_q, digits_n;
    logic [CW-1:0]     cursor_q, cursor_n;
    logic              en_q, en_n;
    logic              err_q, err_n;
    logic              valid_q;

    logic              press;
    logic              onehot;
    logic              is_digit;
    logic              is_star;
    logic              is_hash;
    logic [3:0]        dval;

    logic              wr_en;
    logic [CW-1:0]     wr_idx;
    logic [3:0]        wr_val;

    assign press    = bus.valid & ~valid_q;
    assign onehot   = (bus.scan_data != 12'd0) &&
                      ((bus.scan_data & (bus.scan_data - 12'd1)) == 12'd0);
    assign is_star  = bus.scan_data[9];
    assign is_hash  = bus.scan_data[11];
    assign is_digit = (|bus.scan_data[8:0]) | bus.scan_data[10];

    // Bit 10 is the zero key, so leaving dval at 0 covers it.
    always_comb begin
        dval = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (bus.scan_data[i]) begin
                dval = 4'(i + 1);
            end
        end
    end

    always_comb begin
        cursor_n = cursor_q;
        en_n     = en_q;
        err_n    = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = cursor_q;
        wr_val   = dval;

        if (press) begin
            if (!onehot || en_q) begin
                err_n = 1'b1;
            end else if (is_star) begin
                en_n = 1'b1;
            end else if (AUTO_ADV == 0) begin
                if (is_digit) begin
                    wr_en = 1'b1;
                end else if (is_hash && cursor_q < CW'(NDIG - 1)) begin
                    cursor_n = cursor_q + CW'(1);
                end else begin
                    err_n = 1'b1;
                end
            end else begin
                if (is_digit) begin
                    if (cursor_q < CW'(NDIG)) begin
                        wr_en    = 1'b1;
                        cursor_n = cursor_q + CW'(1);
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (is_hash && cursor_q != CW'(0)) begin
                    // Backspace: step back and blank the slot just vacated.
                    wr_en    = 1'b1;
                    wr_idx   = cursor_q - CW'(1);
                    wr_val   = 4'd0;
                    cursor_n = cursor_q - CW'(1);
                end else begin
                    err_n = 1'b1;
                end
            end
        end
    end

    always_comb begin
        digits_n = digits_q;
        for (int i = 0; i < NDIG; i++) begin
            if (wr_en && wr_idx == CW'(i)) begin
                digits_n[4*i +: 4] = wr_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits_q <= '0;
            cursor_q <= '0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            // valid_q keeps tracking valid through clear so a key held
            // across the clear is not seen as a fresh press afterwards.
            valid_q <= bus.valid;
            if (bus.clear) begin
                digits_q <= '0;
                cursor_q <= '0;
                en_q     <= 1'b0;
                err_q    <= 1'b0;
            end else begin
                digits_q <= digits_n;
                cursor_q <= cursor_n;
                en_q     <= en_n;
                err_q    <= err_n;
            end
        end
    end

    assign bus.digits = digits_q;
    assign bus.cursor = cursor_q;
    assign bus.en     = en_q;
    assign bus.err    = err_q;
    assign bus.full   = (AUTO_ADV != 0) ? (cursor_q == CW'(NDIG))
                                        : (cursor_q == CW'(NDIG - 1));

endmodule

// File: tb/tb_keypad_digit_buf.sv
// tb/tb_keypad_digit_buf.sv - self-checking bench for keypad_digit_buf in both entry modes
module tb_keypad_digit_buf;

    logic clk;
    logic rst;

    keypad_digit_buf_if #(.NDIG(6)) bus0 ();
    keypad_digit_buf_if #(.NDIG(4)) bus1 ();

    keypad_digit_buf #(.NDIG(6), .AUTO_ADV(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    keypad_digit_buf #(.NDIG(4), .AUTO_ADV(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: index 0 = cursor mode NDIG=6, index 1 = auto-advance NDIG=4.
    int m_dig [2][6];
    int m_cur [2];
    bit m_en  [2];
    bit m_err [2];
    bit m_vq  [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] key(input int d);
        logic [11:0] c;
        if (d == 0)       c = 12'h400;
        else if (d <= 9)  c = 12'(1) << (d - 1);
        else if (d == 10) c = 12'h200;   // *
        else              c = 12'h800;   // #
        return c;
    endfunction

    function automatic logic [63:0] exp_digits(input int m);
        logic [63:0] e;
        int nd;
        nd = (m == 0) ? 6 : 4;
        e = 64'd0;
        for (int i = 0; i < nd; i++) e = e | (64'(m_dig[m][i]) << (4 * i));
        return e;
    endfunction

    task automatic model_zero(input int m);
        for (int i = 0; i < 6; i++) m_dig[m][i] = 0;
        m_cur[m] = 0;
        m_en[m]  = 1'b0;
        m_err[m] = 1'b0;
    endtask

    task automatic model_step(input int m, input bit v, input logic [11:0] code, input bit clr);
        int nd;
        int k;
        int d;
        bit pr;
        nd = (m == 0) ? 6 : 4;
        pr = v && !m_vq[m];
        m_vq[m]  = v;
        m_err[m] = 1'b0;
        if (clr) begin
            model_zero(m);
            return;
        end
        if (!pr) return;
        if ($countones(code) != 1 || m_en[m]) begin
            m_err[m] = 1'b1;
            return;
        end
        k = 0;
        for (int i = 0; i < 12; i++) if (code[i]) k = i;
        if (k == 9) begin
            m_en[m] = 1'b1;
        end else if (k == 11) begin
            if (m == 0) begin
                if (m_cur[m] < nd - 1) m_cur[m]++;
                else m_err[m] = 1'b1;
            end else begin
                if (m_cur[m] > 0) begin
                    m_cur[m]--;
                    m_dig[m][m_cur[m]] = 0;
                end else m_err[m] = 1'b1;
            end
        end else begin
            d = (k == 10) ? 0 : k + 1;
            if (m == 0) begin
                m_dig[m][m_cur[m]] = d;
            end else if (m_cur[m] < nd) begin
                m_dig[m][m_cur[m]] = d;
                m_cur[m]++;
            end else begin
                m_err[m] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        check("m0_digits", 64'(bus0.digits), exp_digits(0));
        check("m0_cursor", 64'(bus0.cursor), 64'(m_cur[0]));
        check("m0_full",   64'(bus0.full),   64'(m_cur[0] == 5));
        check("m0_en",     64'(bus0.en),     64'(m_en[0]));
        check("m0_err",    64'(bus0.err),    64'(m_err[0]));
        check("m1_digits", 64'(bus1.digits), exp_digits(1));
        check("m1_cursor", 64'(bus1.cursor), 64'(m_cur[1]));
        check("m1_full",   64'(bus1.full),   64'(m_cur[1] == 4));
        check("m1_en",     64'(bus1.en),     64'(m_en[1]));
        check("m1_err",    64'(bus1.err),    64'(m_err[1]));
    endtask

    task automatic drive(input bit v, input logic [11:0] code, input bit clr);
        bus0.valid = v; bus0.scan_data = code; bus0.clear = clr;
        bus1.valid = v; bus1.scan_data = code; bus1.clear = clr;
    endtask

    // Called at a falling edge: apply inputs, let one rising edge pass,
    // then advance the reference and compare at the next falling edge.
    task automatic step(input bit v, input logic [11:0] code, input bit clr);
        drive(v, code, clr);
        @(negedge clk);
        model_step(0, v, code, clr);
        model_step(1, v, code, clr);
        check_all();
    endtask

    task automatic press(input int d);
        step(1'b1, key(d), 1'b0);
        step(1'b0, key(d), 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 12'h000, 1'b1);
        step(1'b0, 12'h000, 1'b0);
    endtask

    initial begin
        logic [11:0] code;
        int r;
        bit v;
        bit clr;

        for (int m = 0; m < 2; m++) begin
            model_zero(m);
            m_vq[m] = 1'b0;
        end
        rst = 1'b0;
        drive(1'b0, 12'h000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b1;
        @(negedge clk);
        check_all();

        // Cursor-mode entry 5 # 7 # 3.
        press(5); press(11); press(7); press(11); press(3);
        check("m0_seq_digits", 64'(bus0.digits[11:0]), 64'h375);
        check("m0_seq_cursor", 64'(bus0.cursor), 64'd2);
        check("m1_seq_digits", 64'(bus1.digits), 64'h0003);
        check("m1_seq_cursor", 64'(bus1.cursor), 64'd1);

        // Cursor saturation in mode 0.
        do_clear();
        for (int i = 0; i < 5; i++) press(11);
        check("m0_hash5_cursor", 64'(bus0.cursor), 64'd5);
        check("m0_hash5_full", 64'(bus0.full), 64'd1);
        step(1'b1, key(11), 1'b0);
        check("m0_hash6_err", 64'(bus0.err), 64'd1);
        step(1'b0, key(11), 1'b0);
        check("m0_hash6_err_gone", 64'(bus0.err), 64'd0);
        check("m0_hash6_cursor", 64'(bus0.cursor), 64'd5);

        // Auto-advance fill, overflow, backspace.
        do_clear();
        press(1); press(2); press(3); press(4);
        check("m1_fill_digits", 64'(bus1.digits), 64'h4321);
        check("m1_fill_full", 64'(bus1.full), 64'd1);
        step(1'b1, key(9), 1'b0);
        check("m1_over_err", 64'(bus1.err), 64'd1);
        step(1'b0, key(9), 1'b0);
        press(11);
        check("m1_bs_cursor", 64'(bus1.cursor), 64'd3);
        check("m1_bs_digits", 64'(bus1.digits), 64'h0321);

        // Held key, then a two-hot code.
        for (int i = 0; i < 10; i++) step(1'b1, key(8), 1'b0);
        step(1'b0, key(8), 1'b0);
        step(1'b1, 12'h003, 1'b0);
        check("m0_twohot_err", 64'(bus0.err), 64'd1);
        step(1'b0, 12'h003, 1'b0);

        // Commit lock, then clear coincident with a press edge.
        do_clear();
        press(4); press(2); press(10);
        check("m0_lock_en", 64'(bus0.en), 64'd1);
        press(6);
        step(1'b1, key(5), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, key(5), 1'b0);
        check("m0_clr_digits", 64'(bus0.digits), 64'd0);
        step(1'b0, key(5), 1'b0);

        // Async reset mid-entry with a key already held.
        press(1); press(2); press(3);
        check("m1_pre_rst_cursor", 64'(bus1.cursor), 64'd3);
        drive(1'b1, key(7), 1'b0);
        #2 rst = 1'b0;
        #1;
        check("rst_async_m0_digits", 64'(bus0.digits), 64'd0);
        check("rst_async_m1_digits", 64'(bus1.digits), 64'd0);
        check("rst_async_m1_cursor", 64'(bus1.cursor), 64'd0);
        check("rst_async_m0_cursor", 64'(bus0.cursor), 64'd0);
        for (int m = 0; m < 2; m++) begin
            model_zero(m);
            m_vq[m] = 1'b0;
        end
        #1 rst = 1'b1;
        @(negedge clk);
        model_step(0, 1'b1, key(7), 1'b0);
        model_step(1, 1'b1, key(7), 1'b0);
        check_all();
        step(1'b0, key(7), 1'b0);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            r = int'($urandom % 16);
            if (r <= 9) code = key(r);
            else if (r <= 11 || r == 15) code = key(11);
            else if (r == 12) code = key(10);
            else if (r == 13) begin
                code = 12'($urandom);
                if ($countones(code) == 1) code = 12'h003;
            end else code = 12'h000;
            v   = 1'($urandom);
            clr = ($urandom % 25) == 0;
            step(v, code, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
